fft_result_sink: RTL

- Receive end of the FFT output AXI-stream: captures one FFT result frame into an internal buffer.
- Checks frame length against FFT_LENGTH and exposes a registered random-access readback port for the host/bench.
- Sits downstream of the FFT core output, mirroring the stimulus source that feeds the core input.

---
 rtl/fft_tb_pkg.sv | 21 ++
 rtl/fft_sink_ram.sv | 35 +++
 rtl/fft_result_sink.sv | 135 +++++++++++++
 3 files changed

// File: rtl/fft_tb_pkg.sv
// Shared definitions for the FFT stimulus source and result sink.
// Holds the state encoding and the default frame geometry.
package fft_tb_pkg;

    localparam int DEF_FFT_LENGTH = 1024;
    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_ADDR_WIDTH = 10;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        DRAIN   = 2'd2,
        DONE    = 2'd3
    } sink_state_t;

    // True in the states where the sink accepts beats from the stream.
    function automatic logic is_receiving(input sink_state_t s);
        return (s == CAPTURE) || (s == DRAIN);
    endfunction

endpackage

// File: rtl/fft_sink_ram.sv
// Simple dual-port frame buffer: one write port and one registered, read-first read port.
// Kept primitive-like so it can later be swapped for a vendor block RAM.
module fft_sink_ram #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    // NOTE: the array has no reset branch; resetting it would stop it mapping to RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // A read of an address being written this cycle sees the previous contents.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/fft_result_sink.sv
// Receive end of the FFT output stream: captures one frame, checks its length, offers readback.
// Optional FFT_SINK_CKSUM_EN adds a running 32-bit sum of captured samples on port cksum.
module fft_result_sink
    import fft_tb_pkg::*;
#(
    parameter int FFT_LENGTH = DEF_FFT_LENGTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  capture_start,
    input  logic [DATA_WIDTH-1:0] m_axi_data,
    input  logic                  m_axi_valid,
    input  logic                  m_axi_last,
    output logic                  m_axi_ready,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  busy,
    output logic                  capture_done,
    output logic                  err_short,
    output logic                  err_long,
`ifdef FFT_SINK_CKSUM_EN
    output logic [31:0]           cksum,
`endif
    output logic [15:0]           frame_cnt
);

    // One extra address bit so a full 2^ADDR_WIDTH frame compares without wrapping.
    localparam logic [ADDR_WIDTH:0] LAST_IDX = (ADDR_WIDTH+1)'(FFT_LENGTH - 1);
    localparam logic [ADDR_WIDTH:0] ADDR_ONE = (ADDR_WIDTH+1)'(1);

    sink_state_t         state;
    logic [ADDR_WIDTH:0] wr_addr;
    logic                beat;
    logic                wr_en;
    logic                arm;

    assign beat  = m_axi_valid & m_axi_ready;
    assign wr_en = beat & (state == CAPTURE);
    assign arm   = capture_start & ((state == IDLE) || (state == DONE));

    fft_sink_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en),
        .wr_addr (wr_addr[ADDR_WIDTH-1:0]),
        .wr_data (m_axi_data),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    // Outputs are registered alongside the state so ready/busy track the next state exactly.
    // NOTE: every register here is assigned with <= so all of them update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            wr_addr      <= '0;
            m_axi_ready  <= 1'b0;
            busy         <= 1'b0;
            capture_done <= 1'b0;
            err_short    <= 1'b0;
            err_long     <= 1'b0;
            frame_cnt    <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (arm) begin
                        state        <= CAPTURE;
                        wr_addr      <= '0;
                        m_axi_ready  <= 1'b1;
                        busy         <= 1'b1;
                        capture_done <= 1'b0;
                        err_short    <= 1'b0;
                        err_long     <= 1'b0;
                    end
                end

                CAPTURE: begin
                    if (beat) begin
                        wr_addr <= wr_addr + ADDR_ONE;
                        if (m_axi_last) begin
                            state        <= DONE;
                            m_axi_ready  <= 1'b0;
                            busy         <= 1'b0;
                            capture_done <= 1'b1;
                            frame_cnt    <= frame_cnt + 16'd1;
                            if (wr_addr != LAST_IDX) begin
                                err_short <= 1'b1;
                            end
                        end else if (wr_addr == LAST_IDX) begin
                            state    <= DRAIN;
                            err_long <= 1'b1;
                        end
                    end
                end

                DRAIN: begin
                    if (beat && m_axi_last) begin
                        state        <= DONE;
                        m_axi_ready  <= 1'b0;
                        busy         <= 1'b0;
                        capture_done <= 1'b1;
                        frame_cnt    <= frame_cnt + 16'd1;
                    end
                end

                default: begin
                    state       <= IDLE;
                    m_axi_ready <= 1'b0;
                    busy        <= 1'b0;
                end
            endcase
        end
    end

`ifdef FFT_SINK_CKSUM_EN
    // Sums only samples that land in the buffer; drained overflow beats are excluded.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cksum <= '0;
        end else if (arm) begin
            cksum <= '0;
        end else if (wr_en) begin
            cksum <= cksum + 32'(m_axi_data);
        end
    end
`endif

endmodule
